multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/types_pkg.sv | 85 ++++++++
 rtl/multicycle_controller_alu_decoder.sv | 35 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared encodings for the multicycle RV32 datapath: opcodes, ALU operations,
// mux selections and the controller state codes.
package types_pkg;

    typedef enum logic [6:0] {
        OP_LOAD      = 7'b0000011,
        OP_I_ARITH   = 7'b0010011,
        OP_S_TYPE    = 7'b0100011,
        OP_R_TYPE    = 7'b0110011,
        OP_RV64_TYPE = 7'b0111011,
        OP_B_TYPE    = 7'b1100011,
        OP_J_TYPE    = 7'b1101111
    } opcode_e;

    // Low eight codes follow funct3 one-to-one.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } aluop_e;

    typedef enum logic [1:0] {
        ALUOP_LUI         = 2'b00,
        ALUOP_BRANCH      = 2'b01,
        ALUOP_R_OR_I_TYPE = 2'b10
    } aluop_type_e;

    typedef enum logic [1:0] {
        RESULT_ALU  = 2'b00,
        RESULT_MEM  = 2'b01,
        RESULT_JUMP = 2'b10
    } resultsrc_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_HALT     = 4'd11;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    function automatic immsrc_e imm_src_of(input logic [6:0] opcode);
        immsrc_e imm;
        case (opcode)
            OP_S_TYPE: imm = IMM_S;
            OP_B_TYPE: imm = IMM_B;
            OP_J_TYPE: imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the coarse ALU operation class plus funct3/funct7 bit 30 to an ALU opcode.
module alu_decoder
    import types_pkg::*;
(
    input  aluop_type_e aluop_type_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        is_rtype_i,
    output aluop_e      alu_control_o
);

    // Immediate forms never subtract, so bit 30 only selects SUB for R-type.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_type_i)
            ALUOP_LUI:    alu_control_o = ALU_ADD;
            ALUOP_BRANCH: alu_control_o = ALU_SUB;
            ALUOP_R_OR_I_TYPE: begin
                case (funct3_i)
                    F3_ADD_SUB: alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:     alu_control_o = ALU_SLL;
                    3'b010:     alu_control_o = ALU_SLT;
                    3'b011:     alu_control_o = ALU_SLTU;
                    3'b100:     alu_control_o = ALU_XOR;
                    F3_SRL_SRA: alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:     alu_control_o = ALU_OR;
                    3'b111:     alu_control_o = ALU_AND;
                    default:    alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of a multicycle RV32 core: sequences fetch, decode, execute, memory
// and write-back, driving datapath mux selects and write strobes.
module multicycle_controller
    import types_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       adr_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [1:0] imm_src_o,
    output logic [3:0] alu_control_o,
    output logic       illegal_o
);

    state_t      state_q, state_d;
    logic        mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, illegal_s;
    resultsrc_e  result_src_s;
    aluop_type_e aluop_type_s;
    aluop_e      alu_control_s;

    // State register; reset lands in FETCH even from a pending memory wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state controls; mem_ready_i is only looked at in memory states.
    always_comb begin
        state_d      = state_q;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        adr_src_o    = 1'b0;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        result_src_s = RESULT_ALU;
        aluop_type_s = ALUOP_LUI;
        case (state_q)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_s = RESULT_JUMP;
                if (mem_ready_i) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLD_PC;
                alu_src_b_o = SRC_B_IMM;
                case (opcode_i)
                    OP_LOAD, OP_S_TYPE: state_d = S_MEMADR;
                    OP_R_TYPE:          state_d = S_EXECR;
                    OP_I_ARITH:         state_d = S_EXECI;
                    OP_B_TYPE:          state_d = S_BRANCH;
                    OP_J_TYPE:          state_d = S_JAL;
                    default:            state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                state_d     = (opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_o = 1'b1;
                state_d   = mem_ready_i ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_s = RESULT_MEM;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_o   = 1'b1;
                state_d     = mem_ready_i ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = (state_q == S_EXECR) ? SRC_B_RS2 : SRC_B_IMM;
                aluop_type_s = ALUOP_R_OR_I_TYPE;
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = RESULT_ALU;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_RS2;
                aluop_type_s = ALUOP_BRANCH;
                result_src_s = RESULT_ALU;
                case (funct3_i)
                    F3_BEQ:  pc_write_s = zero_i;
                    F3_BNE:  pc_write_s = ~zero_i;
                    default: pc_write_s = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_o  = SRC_A_OLD_PC;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_s = RESULT_ALU;
                pc_write_s   = 1'b1;
                state_d      = S_ALUWB;
            end
            S_HALT: begin
                illegal_s = 1'b1;
                state_d   = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are forced low for the whole reset-asserted cycle, not just after the edge.
    assign mem_req_o    = mem_req_s   & rst_n;
    assign mem_write_o  = mem_write_s & rst_n;
    assign ir_write_o   = ir_write_s  & rst_n;
    assign pc_write_o   = pc_write_s  & rst_n;
    assign reg_write_o  = reg_write_s & rst_n;
    assign illegal_o    = illegal_s   & rst_n;
    assign result_src_o = result_src_s;
    assign imm_src_o    = imm_src_of(opcode_i);
    assign alu_control_o = alu_control_s;

    alu_decoder u_alu_decoder (
        .aluop_type_i  (aluop_type_s),
        .funct3_i      (funct3_i),
        .funct7b5_i    (funct7b5_i),
        .is_rtype_i    (opcode_i == OP_R_TYPE),
        .alu_control_o (alu_control_s)
    );

endmodule
